// File: rtl/keccak_pkg.sv
// Shared definitions for the keccak core arbiter: default widths and FSM states.
package keccak_pkg;

  localparam int unsigned KeccakWin  = 32;
  localparam int unsigned KeccakWout = 32;
  localparam int unsigned KeccakLenW = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/keccak_arb_rr.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the one not served last.
module keccak_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic valid
);

  // Winner selection
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak_top core between two requesters, one whole transaction at a time.
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int unsigned WIN   = KeccakWin,
  parameter int unsigned WOUT  = KeccakWout,
  parameter int unsigned LEN_W = KeccakLenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] in_words0,
  input  logic [LEN_W-1:0] in_words1,
  input  logic [LEN_W-1:0] out_words0,
  input  logic [LEN_W-1:0] out_words1,
  output logic             grant0,
  output logic             grant1,
  input  logic             din0_valid,
  input  logic             din1_valid,
  output logic             din0_ready,
  output logic             din1_ready,
  input  logic [WIN-1:0]   din0,
  input  logic [WIN-1:0]   din1,
  output logic             dout0_valid,
  output logic             dout1_valid,
  input  logic             dout0_ready,
  input  logic             dout1_ready,
  output logic [WOUT-1:0]  dout0,
  output logic [WOUT-1:0]  dout1,
  output logic             core_din_valid,
  input  logic             core_din_ready,
  output logic [WIN-1:0]   core_din,
  input  logic             core_dout_valid,
  output logic             core_dout_ready,
  input  logic [WOUT-1:0]  core_dout,
  output logic             busy,
  output logic             txn_done
);

  arb_state_e       state_q, state_d;
  logic             winner_q, winner_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] in_len_q, in_len_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;

  logic             rr_winner, rr_valid;
  logic             streaming, in_open, out_open, in_hs, out_hs;
  logic [LEN_W-1:0] in_cnt_inc, out_cnt_inc;
  logic             sel_din_valid, sel_dout_ready;
  logic [WIN-1:0]   sel_din;

  keccak_arb_rr u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .winner     (rr_winner),
    .valid      (rr_valid)
  );

  // Routing of the granted requester's streams to the core; everything else held at zero
  always_comb begin
    streaming      = (state_q == StStream);
    in_open        = streaming && (in_cnt_q < in_len_q);
    out_open       = streaming && (out_cnt_q < out_len_q);
    sel_din_valid  = winner_q ? din1_valid : din0_valid;
    sel_din        = winner_q ? din1 : din0;
    sel_dout_ready = winner_q ? dout1_ready : dout0_ready;

    core_din_valid  = in_open & sel_din_valid;
    core_din        = in_open ? sel_din : '0;
    core_dout_ready = out_open & sel_dout_ready;
    din0_ready      = in_open & ~winner_q & core_din_ready;
    din1_ready      = in_open & winner_q & core_din_ready;
    dout0_valid     = out_open & ~winner_q & core_dout_valid;
    dout1_valid     = out_open & winner_q & core_dout_valid;
    dout0           = (out_open && !winner_q) ? core_dout : '0;
    dout1           = (out_open && winner_q) ? core_dout : '0;

    grant0   = streaming & ~winner_q;
    grant1   = streaming & winner_q;
    busy     = streaming;
    txn_done = (state_q == StDone);

    in_hs       = core_din_valid & core_din_ready;
    out_hs      = core_dout_valid & core_dout_ready;
    // Counters stop at their lengths because the handshake is gated off once full
    in_cnt_inc  = in_cnt_q + LEN_W'(in_hs);
    out_cnt_inc = out_cnt_q + LEN_W'(out_hs);
  end

  // Arbitration and transaction sequencing
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    in_len_d     = in_len_q;
    out_len_d    = out_len_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          winner_d  = rr_winner;
          in_len_d  = rr_winner ? in_words1 : in_words0;
          out_len_d = rr_winner ? out_words1 : out_words0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = StStream;
        end
      end
      StStream: begin
        in_cnt_d  = in_cnt_inc;
        out_cnt_d = out_cnt_inc;
        if ((in_cnt_inc == in_len_q) && (out_cnt_inc == out_len_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        last_grant_d = winner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      in_len_q     <= '0;
      out_len_q    <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      in_len_q     <= in_len_d;
      out_len_q    <= out_len_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Self-checking bench for keccak_arbiter with a behavioural stand-in for the keccak core.
module tb_keccak_arbiter;

  localparam logic [31:0] XInit = 32'h6A09E667;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, grant, din_valid, din_ready, dout_valid, dout_ready;
  logic [31:0] din [2];
  logic [31:0] dout [2];
  logic [15:0] in_words [2];
  logic [15:0] out_words [2];
  logic        core_din_valid, core_din_ready, core_dout_valid, core_dout_ready;
  logic [31:0] core_din, core_dout;
  logic        busy, txn_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit abort = 1'b0;
  int txn_in_len [2];
  int txn_out_len [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  // Monitor bookkeeping
  logic [1:0] prev_grant = 2'b00;
  int hs_in = 0, hs_out = 0, lat_in = 0, lat_out = 0, dur = 0, gap = 0;
  int done_cnt = 0, g1_cycles = 0;
  int grant_log [$];
  int gap_log [$];
  int dur_log [$];

  keccak_arbiter #(.WIN(32), .WOUT(32), .LEN_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0            (req[0]),
    .req1            (req[1]),
    .in_words0       (in_words[0]),
    .in_words1       (in_words[1]),
    .out_words0      (out_words[0]),
    .out_words1      (out_words[1]),
    .grant0          (grant[0]),
    .grant1          (grant[1]),
    .din0_valid      (din_valid[0]),
    .din1_valid      (din_valid[1]),
    .din0_ready      (din_ready[0]),
    .din1_ready      (din_ready[1]),
    .din0            (din[0]),
    .din1            (din[1]),
    .dout0_valid     (dout_valid[0]),
    .dout1_valid     (dout_valid[1]),
    .dout0_ready     (dout_ready[0]),
    .dout1_ready     (dout_ready[1]),
    .dout0           (dout[0]),
    .dout1           (dout[1]),
    .core_din_valid  (core_din_valid),
    .core_din_ready  (core_din_ready),
    .core_din        (core_din),
    .core_dout_valid (core_dout_valid),
    .core_dout_ready (core_dout_ready),
    .core_dout       (core_dout),
    .busy            (busy),
    .txn_done        (txn_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stand-in core function: order-sensitive digest of the message, squeezed per word index
  function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] w);
    return {x[26:0], x[31:27]} + w;
  endfunction

  function automatic logic [31:0] out_word(input logic [31:0] x, input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return x ^ (kk * 32'h9E3779B9) ^ 32'hA5A50F0F;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int n, input logic [31:0] v);
    if (n == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  // Core model: absorbs the routed message, then offers output words until the arbiter closes
  logic [31:0] c_x;
  int c_abs, c_k, c_in_len;
  bit c_loaded, c_clr, c_take;
  logic [1:0] c_pg;
  initial begin
    core_din_ready = 1'b0; core_dout_valid = 1'b0; core_dout = '0;
    c_x = XInit; c_abs = 0; c_k = 0; c_in_len = 0;
    c_loaded = 1'b0; c_clr = 1'b0; c_take = 1'b0; c_pg = 2'b00;
    forever begin
      @(negedge clk);
      if (c_clr) begin
        c_x = XInit; c_abs = 0; c_k = 0; c_loaded = 1'b0;
        core_dout_valid = 1'b0; core_dout = '0; c_clr = 1'b0; c_take = 1'b0;
      end
      if (c_take) begin
        core_dout_valid = 1'b0; c_k++; c_take = 1'b0;
      end
      core_din_ready = 1'($urandom_range(0, 99) < 70);
      if (!core_dout_valid && c_loaded && c_abs == c_in_len && $urandom_range(0, 99) < 60) begin
        core_dout_valid = 1'b1;
        core_dout = out_word(c_x, c_k);
      end
      #3;
      if (rst || txn_done) begin
        c_clr = 1'b1; c_pg = 2'b00;
      end else begin
        if (grant != 2'b00 && c_pg == 2'b00) begin
          c_in_len = txn_in_len[grant[1]]; c_loaded = 1'b1;
        end
        if (core_din_valid && core_din_ready) begin
          c_x = mix(c_x, core_din); c_abs++;
        end
        if (core_dout_valid && core_dout_ready) c_take = 1'b1;
        c_pg = grant;
      end
    end
  end

  // Monitor and scoreboard: samples just before each rising edge
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    #3;
    if (rst) begin
      prev_grant = 2'b00; gap = 0; dur = 0; hs_in = 0; hs_out = 0;
    end else begin
      check(grant != 2'b11, "grant_exclusive", 32'(grant), 32'h1);
      check(busy == (grant != 2'b00), "busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
      if (grant == 2'b00) begin
        check({din_ready, dout_valid, core_din_valid, core_dout_ready} == 6'b0, "idle_quiet",
              32'({din_ready, dout_valid, core_din_valid, core_dout_ready}), 32'h0);
        check(dout[0] == '0 && dout[1] == '0, "idle_dout_zero", dout[0] | dout[1], 32'h0);
      end
      for (int n = 0; n < 2; n++) begin
        if (!grant[n]) check(!dout_valid[n] && !din_ready[n], "ungranted_quiet",
                             32'({dout_valid[n], din_ready[n]}), 32'h0);
      end
      if (prev_grant != 2'b00 && grant == 2'b00)
        check(txn_done, "done_after_grant", 32'(txn_done), 32'h1);
      else
        check(!txn_done, "done_only_at_end", 32'(txn_done), 32'h0);
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        grant_log.push_back(int'(grant[1]));
        gap_log.push_back(gap);
        gap = 0; dur = 0; hs_in = 0; hs_out = 0;
        lat_in = txn_in_len[grant[1]]; lat_out = txn_out_len[grant[1]];
      end
      if (grant != 2'b00) dur++; else gap++;
      if (grant[1]) g1_cycles++;
      if (core_din_valid && core_din_ready) hs_in++;
      if (core_dout_valid && core_dout_ready) hs_out++;
      for (int n = 0; n < 2; n++) begin
        if (dout_valid[n] && dout_ready[n]) begin
          if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
            check(1'b0, "unexpected_dout", dout[n], 32'(n));
          end else begin
            e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(dout[n] == e, "dout_data", dout[n], e);
          end
        end
      end
      if (txn_done) begin
        done_cnt++;
        dur_log.push_back(dur);
        check(hs_in == lat_in, "core_in_handshakes", 32'(hs_in), 32'(lat_in));
        check(hs_out == lat_out, "core_out_handshakes", 32'(hs_out), 32'(lat_out));
      end
      prev_grant = grant;
    end
  end

  task automatic drive_din(input int n, input logic [31:0] w[$], input int gmax);
    int k = 0, g = 0, b = 0;
    g = $urandom_range(0, gmax);
    while (k < w.size() && !abort && b < 3000) begin
      @(negedge clk);
      b++;
      if (g > 0) begin
        din_valid[n] = 1'b0; g--;
      end else begin
        din_valid[n] = 1'b1; din[n] = w[k];
        #2;
        if (din_ready[n]) begin
          k++; g = $urandom_range(0, gmax);
        end
      end
    end
    if (b >= 3000) check(1'b0, "din_timeout", 32'(k), 32'(w.size()));
    @(negedge clk);
    din_valid[n] = 1'b0;
  endtask

  task automatic drive_dout(input int n, input int outw, input int pct);
    int cnt = 0, b = 0;
    while (cnt < outw && !abort && b < 3000) begin
      @(negedge clk);
      b++;
      dout_ready[n] = 1'($urandom_range(0, 99) < pct);
      #2;
      if (dout_valid[n] && dout_ready[n]) cnt++;
    end
    if (b >= 3000) check(1'b0, "dout_timeout", 32'(cnt), 32'(outw));
    @(negedge clk);
    dout_ready[n] = 1'b0;
  endtask

  // One transaction from requester n; expected output words are queued at issue
  task automatic do_txn(input int n, input int inw, input int outw, input int gmax,
                        input int pct, output int lat);
    logic [31:0] w[$];
    logic [31:0] x;
    int c0, b;
    bit got;
    x = XInit;
    for (int k = 0; k < inw; k++) begin
      w.push_back($urandom);
      x = mix(x, w[k]);
    end
    for (int k = 0; k < outw; k++) push_exp(n, out_word(x, k));
    @(negedge clk);
    txn_in_len[n] = inw; txn_out_len[n] = outw;
    in_words[n] = 16'(inw); out_words[n] = 16'(outw);
    req[n] = 1'b1;
    c0 = cyc; b = 0; got = 1'b0;
    do begin
      #3;
      got = grant[n];
      if (!got) begin
        b++;
        @(negedge clk);
      end
    end while (!got && !abort && b < 3000);
    lat = cyc - c0;
    if (!got && !abort) check(1'b0, "grant_timeout", 32'(n), 32'h1);
    @(negedge clk);
    req[n] = 1'b0;
    in_words[n] = 16'($urandom); out_words[n] = 16'($urandom);
    if (got) begin
      fork
        drive_din(n, w, gmax);
        drive_dout(n, outw, pct);
      join
    end
  endtask

  task automatic check_drained(input string name);
    check(exp_q0.size() == 0 && exp_q1.size() == 0, name,
          32'(exp_q0.size() + exp_q1.size()), 32'h0);
  endtask

  initial begin
    int l0, l1, d0, g0, b;
    rst = 1'b1; req = '0; din_valid = '0; dout_ready = '0;
    din[0] = '0; din[1] = '0;
    in_words[0] = '0; in_words[1] = '0; out_words[0] = '0; out_words[1] = '0;
    txn_in_len[0] = 0; txn_in_len[1] = 0; txn_out_len[0] = 0; txn_out_len[1] = 0;
    repeat (2) @(negedge clk);
    #2;
    check(grant == 2'b00 && !busy && !txn_done, "reset_ctrl", 32'({grant, busy, txn_done}), 0);
    check({din_ready, dout_valid, core_din_valid, core_dout_ready} == 6'b0, "reset_streams",
          32'({din_ready, dout_valid, core_din_valid, core_dout_ready}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Both requesting out of reset: 0 first, then 1 after a two-cycle gap
    grant_log.delete(); gap_log.delete();
    fork
      do_txn(0, 3, 5, 2, 70, l0);
      do_txn(1, 2, 4, 2, 70, l1);
    join
    repeat (3) @(negedge clk);
    check(grant_log.size() == 2, "tie_grant_count", 32'(grant_log.size()), 32'h2);
    if (grant_log.size() == 2) begin
      check(grant_log[0] == 0 && grant_log[1] == 1, "tie_order",
            32'({grant_log[0][0], grant_log[1][0]}), 32'h1);
      check(gap_log[1] == 2, "tie_gap", 32'(gap_log[1]), 32'h2);
    end
    check(l0 == 1, "tie_grant_latency", 32'(l0), 32'h1);
    check_drained("tie_drained");

    // Continuous re-requests alternate
    grant_log.delete(); gap_log.delete();
    fork
      repeat (2) do_txn(0, $urandom_range(1, 5), $urandom_range(1, 5), 2, 70, l0);
      repeat (2) do_txn(1, $urandom_range(1, 5), $urandom_range(1, 5), 2, 70, l1);
    join
    repeat (3) @(negedge clk);
    check(grant_log.size() == 4, "alt_grant_count", 32'(grant_log.size()), 32'h4);
    for (int i = 0; i < grant_log.size(); i++) begin
      check(grant_log[i] == (i % 2), "alt_order", 32'(grant_log[i]), 32'(i % 2));
      if (i > 0) check(gap_log[i] == 2, "alt_gap", 32'(gap_log[i]), 32'h2);
    end
    check_drained("alt_drained");

    // Lone requester 0, 4 in / 8 out
    d0 = done_cnt; g0 = g1_cycles;
    do_txn(0, 4, 8, 2, 80, l0);
    repeat (3) @(negedge clk);
    check(l0 == 1, "single_grant_latency", 32'(l0), 32'h1);
    check(done_cnt - d0 == 1, "single_done_pulses", 32'(done_cnt - d0), 32'h1);
    check(g1_cycles == g0, "single_no_grant1", 32'(g1_cycles - g0), 32'h0);
    check_drained("single_drained");

    // Heavy backpressure on both sides
    do_txn(0, 4, 8, 10, 25, l0);
    repeat (3) @(negedge clk);
    check_drained("bp_drained");

    // Zero-length transaction on requester 1
    d0 = done_cnt;
    do_txn(1, 0, 0, 0, 100, l1);
    repeat (3) @(negedge clk);
    check(l1 == 1, "zero_grant_latency", 32'(l1), 32'h1);
    check(done_cnt - d0 == 1, "zero_done_pulses", 32'(done_cnt - d0), 32'h1);
    if (dur_log.size() > 0) check(dur_log[$] == 1, "zero_grant_cycles", 32'(dur_log[$]), 32'h1);

    // Random mix of lengths, including zeros on either side
    fork
      repeat (3) do_txn(0, $urandom_range(0, 6), $urandom_range(0, 6), 3,
                        $urandom_range(30, 100), l0);
      repeat (3) do_txn(1, $urandom_range(0, 6), $urandom_range(0, 6), 3,
                        $urandom_range(30, 100), l1);
    join
    repeat (3) @(negedge clk);
    check_drained("rand_drained");

    // Asynchronous reset after the second input word
    fork
      do_txn(0, 4, 8, 1, 70, l0);
      begin
        b = 0;
        do begin
          @(negedge clk);
          b++;
        end while (!(grant[0] && hs_in >= 2) && b < 500);
        check(b < 500, "rst_wait_timeout", 32'(b), 32'd500);
        #1 rst = 1'b1;
        #1;
        check(grant == 2'b00 && !busy && !txn_done, "async_rst_ctrl",
              32'({grant, busy, txn_done}), 32'h0);
        check({din_ready, dout_valid, core_din_valid, core_dout_ready} == 6'b0,
              "async_rst_streams",
              32'({din_ready, dout_valid, core_din_valid, core_dout_ready}), 32'h0);
        check(dout[0] == '0 && dout[1] == '0, "async_rst_dout", dout[0] | dout[1], 32'h0);
        abort = 1'b1;
      end
    join
    req = '0; din_valid = '0; dout_ready = '0;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; abort = 1'b0;

    // Full transaction after the reset
    d0 = done_cnt;
    do_txn(0, 4, 8, 2, 70, l0);
    repeat (3) @(negedge clk);
    check(l0 == 1, "post_rst_latency", 32'(l0), 32'h1);
    check(done_cnt - d0 == 1, "post_rst_done", 32'(done_cnt - d0), 32'h1);
    check_drained("post_rst_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
